// File: rtl/stim_gen_pkg.sv
// rtl/stim_gen_pkg.sv - shared encodings and vector mapping for the stimulus sequencer
package stim_gen_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_WALK = 2'd2,
        MODE_DOWN = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LEN_FULL = 16;
    localparam int LEN_WALK = 4;

    function automatic logic [3:0] map_vec(input mode_e m, input logic [3:0] k);
        logic [3:0] v;
        case (m)
            MODE_BIN:  v = k;
            MODE_GRAY: v = k ^ (k >> 1);
            MODE_WALK: v = 4'b0001 << k[1:0];
            MODE_DOWN: v = 4'hF - k;
            default:   v = 4'h0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] last_idx(input mode_e m);
        return (m == MODE_WALK) ? 4'(LEN_WALK - 1) : 4'(LEN_FULL - 1);
    endfunction

endpackage

// File: rtl/stim_gen_step.sv
// rtl/stim_gen_step.sv - step_timer: div+1 cycle period counter for vector hold time
module step_timer
    import stim_gen_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] div_q;

    // div is captured at load so later input changes cannot alter the period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            div_q <= '0;
        end else if (load) begin
            count <= div;
            div_q <= div;
        end else if (run) begin
            if (count == '0) begin
                count <= div_q;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign tick = run && (count == '0);

endmodule

// File: rtl/stim_gen.sv
// rtl/stim_gen.sv - programmable 4-bit stimulus sequencer with per-vector strobe
module stim_gen
    import stim_gen_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 d,
    output logic [3:0]           vec_idx,
    output logic                 step_valid,
    output logic                 busy,
    output logic                 done
);

    state_e     state, state_n;
    mode_e      mode_q, mode_n;
    logic [3:0] vec_q, vec_n;
    logic [3:0] idx_q, idx_n;
    logic       sv_q, sv_n;
    logic       accept;
    logic       tick;

    assign accept = (state == ST_IDLE) && start && !stop;

    step_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .run  (state == ST_RUN),
        .div  (div),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_BIN;
            vec_q  <= 4'h0;
            idx_q  <= 4'h0;
            sv_q   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            vec_q  <= vec_n;
            idx_q  <= idx_n;
            sv_q   <= sv_n;
        end
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        vec_n   = 4'h0;
        idx_n   = 4'h0;
        sv_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_RUN;
                    mode_n  = mode_e'(mode);
                    vec_n   = map_vec(mode_e'(mode), 4'h0);
                    sv_n    = 1'b1;
                end
            end
            ST_RUN: begin
                // stop outranks a pending step so no strobe escapes an abort
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    if (idx_q == last_idx(mode_q)) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n = idx_q + 4'h1;
                        vec_n = map_vec(mode_q, idx_q + 4'h1);
                        sv_n  = 1'b1;
                    end
                end else begin
                    idx_n = idx_q;
                    vec_n = vec_q;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign a          = vec_q[0];
    assign b          = vec_q[1];
    assign c          = vec_q[2];
    assign d          = vec_q[3];
    assign vec_idx    = idx_q;
    assign step_valid = sv_q;
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_stim_gen.sv
// tb/tb_stim_gen.sv - scoreboard bench for stim_gen
module tb_stim_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] div = 8'd0;
    logic       a, b, c, d;
    logic [3:0] vec_idx;
    logic       step_valid, busy, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] vec;
        logic [3:0] idx;
        logic       dn;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [3:0] walk_tab [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    stim_gen #(.DIV_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .div        (div),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .vec_idx    (vec_idx),
        .step_valid (step_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_vec(input int m, input int k);
        case (m)
            0:       return 4'(k);
            1:       return gray_tab[k];
            2:       return walk_tab[k];
            default: return 4'(15 - k);
        endcase
    endfunction

    task automatic push_seq(input int m, input int dv, input int t0, input int nvec, input bit with_done);
        exp_t e;
        int n;
        n = (m == 2) ? 4 : 16;
        for (int k = 0; k < nvec; k++) begin
            e.vec = exp_vec(m, k);
            e.idx = 4'(k);
            e.dn  = 1'b0;
            e.cyc = t0 + k * (dv + 1);
            sb.push_back(e);
        end
        if (with_done) begin
            e.vec = 4'h0;
            e.idx = 4'h0;
            e.dn  = 1'b1;
            e.cyc = t0 + n * (dv + 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input int m, input int dv, input int nvec, input bit with_done);
        @(negedge clk);
        mode  = 2'(m);
        div   = 8'(dv);
        start = 1'b1;
        push_seq(m, dv, cyc + 1, nvec, with_done);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || done) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, (n < 3000) ? 1 : 0, 1);
    endtask

    task automatic wait_idx(input int idx, input string name);
        int n;
        n = 0;
        while (!(step_valid && vec_idx == 4'(idx)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reach_idx"}, (n < 500) ? 1 : 0, 1);
    endtask

    task automatic check_zero(input string name);
        check({name, "_vec"}, int'({d, c, b, a}), 0);
        check({name, "_idx"}, int'(vec_idx), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_sv"}, int'(step_valid), 0);
        check({name, "_done"}, int'(done), 0);
    endtask

    // monitor: every strobe or done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && (step_valid || done)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event vec=%0d idx=%0d done=%0d (cycle %0d) expected none",
                         {d, c, b, a}, vec_idx, done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_vec", int'({d, c, b, a}), int'(e.vec));
                check("mon_idx", int'(vec_idx), int'(e.idx));
                check("mon_done", int'(done), int'(e.dn));
                check("mon_cycle", cyc, e.cyc);
                check("mon_busy", int'(busy), e.dn ? 0 : 1);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_reset");

        do_start(0, 0, 16, 1'b1);
        wait_done("bin_div0");
        @(negedge clk);
        check_zero("bin_after_done");

        do_start(1, 2, 16, 1'b1);
        wait_done("gray_div2");

        do_start(2, 1, 4, 1'b1);
        mode = 2'd0;
        div  = 8'd5;
        wait_done("walk_div1");

        do_start(2, 255, 4, 1'b1);
        wait_done("walk_divmax");

        do_start(0, 3, 6, 1'b0);
        wait_idx(5, "stop");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_zero("after_stop");
        repeat (30) @(negedge clk);
        check("stop_sb_empty", sb.size(), 0);

        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        repeat (5) @(negedge clk);

        do_start(3, 1, 4, 1'b0);
        wait_idx(3, "rst_mid");
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        check("rst_sb_empty", sb.size(), 0);

        do_start(3, 0, 16, 1'b1);
        repeat (3) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("down_after_rst");
        repeat (10) @(negedge clk);

        // start held across DONE and the following idle cycle: only the idle one counts
        do_start(2, 0, 4, 1'b1);
        begin
            int n;
            n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_seen", (n < 100) ? 1 : 0, 1);
        end
        start = 1'b1;
        mode  = 2'd0;
        div   = 8'd0;
        push_seq(0, 0, cyc + 2, 16, 1'b1);
        @(negedge clk);
        check_zero("b2b_idle_gap");
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b");
        repeat (5) @(negedge clk);

        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
